// File: rtl/gsim_b_loader_pkg.sv
// Shared GSIM definitions: vector geometry, loader and core state codes.
// Also holds the byte-packing helper used by the b loader.
package gsim_b_loader_pkg;

   localparam int GSIM_NUM_WORDS = 16;
   localparam int GSIM_B_W       = 16;

   typedef enum logic [1:0] {
      GS_IDLE,
      GS_RUN,
      GS_DONE
   } gsim_state_t;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_LOAD,
      LD_BURST,
      LD_WAIT
   } ld_state_t;

   // Merge one byte into a partially built word.
   function automatic logic [15:0] pack_word(
      input logic        lsb_first,
      input logic [15:0] cur,
      input logic [7:0]  b,
      input logic        phase
   );
      logic hi;
      hi = lsb_first ? phase : ~phase;
      return hi ? {b, cur[7:0]} : {cur[15:8], b};
   endfunction

endpackage

// File: rtl/gsim_b_loader_if.sv
// Upstream byte stream handshake into the b loader.
// master drives bytes, slave (the loader) returns ready.
interface gsim_b_loader_if;
   logic       byte_valid;
   logic [7:0] byte_in;
   logic       byte_ready;

   modport master (
      output byte_valid,
      output byte_in,
      input  byte_ready
   );

   modport slave (
      input  byte_valid,
      input  byte_in,
      output byte_ready
   );
endinterface

// File: rtl/gsim_b_loader.sv
// Collects a b vector byte by byte, then streams it to GSIM
// as an unbroken burst of NUM_WORDS words.
module gsim_b_loader
   import gsim_b_loader_pkg::*;
#(
   parameter int NUM_WORDS = GSIM_NUM_WORDS,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   gsim_b_loader_if.slave      bus,
   input  logic                clear,
   output logic                in_en,
   output logic signed [15:0]  b_in,
   output logic                busy
);

   localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

   ld_state_t     state;
   logic [CW-1:0] cnt;
   logic          phase;
   logic [15:0]   bufr [NUM_WORDS];
   logic [15:0]   wr_word;
   logic [CW-1:0] cnt_nx;

   assign wr_word = pack_word(LSB_FIRST, bufr[cnt], bus.byte_in, phase);
   assign cnt_nx  = cnt + CW'(1);

   assign bus.byte_ready = (state == LD_LOAD);
   assign busy           = (state == LD_BURST) || (state == LD_WAIT);

   // Loader FSM: fill buffer, burst it out, then park until cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LD_IDLE;
         cnt   <= '0;
         phase <= 1'b0;
         in_en <= 1'b0;
         b_in  <= '0;
         for (int i = 0; i < NUM_WORDS; i++) bufr[i] <= '0;
      end else begin
         unique case (state)
            LD_IDLE: state <= LD_LOAD;
            LD_LOAD: begin
               if (clear) begin
                  cnt   <= '0;
                  phase <= 1'b0;
               end else if (bus.byte_valid) begin
                  bufr[cnt] <= wr_word;
                  phase     <= ~phase;
                  if (phase) begin
                     if (cnt == LAST) begin
                        state <= LD_BURST;
                        cnt   <= '0;
                        in_en <= 1'b1;
                        b_in  <= (NUM_WORDS == 1) ? wr_word : bufr[0];
                     end else begin
                        cnt <= cnt_nx;
                     end
                  end
               end
            end
            LD_BURST: begin
               if (cnt == LAST) begin
                  state <= LD_WAIT;
                  cnt   <= '0;
                  in_en <= 1'b0;
                  b_in  <= '0;
               end else begin
                  cnt  <= cnt_nx;
                  b_in <= bufr[cnt_nx];
               end
            end
            LD_WAIT: begin
               if (clear) begin
                  state <= LD_LOAD;
                  cnt   <= '0;
                  phase <= 1'b0;
               end
            end
            default: state <= LD_IDLE;
         endcase
      end
   end

endmodule
